// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand widths, the
// iteration-counter width and the controller state encoding.
package div_pkg;

   localparam int unsigned DW_N  = 16;  // dividend / quotient width
   localparam int unsigned DW_D  = 8;   // divisor / remainder width
   localparam int unsigned CNT_W = 5;   // iteration counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   pr_in   : current partial remainder (low DW_D bits)
//   bit_in  : next dividend bit, MSB first
//   divisor : latched divisor
//   pr_next : partial remainder after this step (DW_D+1 bits)
//   q_bit   : quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int unsigned W = DW_D
) (
   input  logic [W-1:0] pr_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W:0]   pr_next,
   output logic         q_bit
);

   logic [W:0] trial;

   always_comb begin
      trial = {pr_in, bit_in};
      if (trial >= {1'b0, divisor}) begin
         pr_next = trial - {1'b0, divisor};
         q_bit   = 1'b1;
      end else begin
         pr_next = trial;
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, DW_N / DW_D, one quotient bit per
// clock, start/done handshake.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only in IDLE
//   dividend     : sampled on the accepted start
//   divisor      : sampled on the accepted start
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse, results valid
//   quotient     : registered result
//   remainder    : registered result
//   div_by_zero  : registered flag, set when the divisor was 0
// Working registers (pr/qsr/dsr) are separate from the result registers so
// the outputs never expose intermediate shift state.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned DW_N = div_pkg::DW_N,
   parameter int unsigned DW_D = div_pkg::DW_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW_N-1:0] dividend,
   input  logic [DW_D-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [DW_N-1:0] quotient,
   output logic [DW_D-1:0] remainder,
   output logic            div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW_N - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW_D:0]    pr_q, pr_d;
   logic [DW_N-1:0]  qsr_q, qsr_d;
   logic [DW_D-1:0]  dsr_q, dsr_d;
   logic [DW_N-1:0]  quot_q, quot_d;
   logic [DW_D-1:0]  rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DW_D:0]    step_pr;
   logic             step_q;

   div_step #(.W(DW_D)) u_step (
      .pr_in   (pr_q[DW_D-1:0]),
      .bit_in  (qsr_q[DW_N-1]),
      .divisor (dsr_q),
      .pr_next (step_pr),
      .q_bit   (step_q)
   );

   // PR's top bit is always 0 once stored: a set MSB forces the subtract,
   // leaving a result below the divisor. It exists only so the compare
   // cannot overflow, and is never fed back.
   logic unused_pr_msb;
   assign unused_pr_msb = pr_q[DW_D];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pr_d    = pr_q;
      qsr_d   = qsr_q;
      dsr_d   = dsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  qsr_d   = dividend;
                  dsr_d   = divisor;
                  pr_d    = '0;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            pr_d  = step_pr;
            qsr_d = {qsr_q[DW_N-2:0], step_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               // Results are committed on the last step so they are already
               // valid during the DONE cycle.
               quot_d  = {qsr_q[DW_N-2:0], step_q};
               rem_d   = step_pr[DW_D-1:0];
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pr_q    <= '0;
         qsr_q   <= '0;
         dsr_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pr_q    <= pr_d;
         qsr_q   <= qsr_d;
         dsr_q   <= dsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
